// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around a single full-adder
// slice. The slice is two half-adder cells plus an OR. Operands are latched
// on an accepted Start and added LSB first, one bit per clock, with the
// carry held in a register between bits.
//
// Optional feature macro: SERIAL_ADDER_CIN_EN. When it is defined, a Cin
// port is added and sampled as the initial carry.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   Start  in   request strobe, sampled only in IDLE
//   A, B   in   WIDTH-bit operands, latched on the accepting Start edge
//   Cin    in   initial carry (only with SERIAL_ADDER_CIN_EN)
//   Busy   out  high while bits are being processed (RUN)
//   Done   out  one-cycle pulse, Sum/Carry valid
//   Sum    out  registered result, held until the next completion
//   Carry  out  registered carry-out of the MSB
//
// State table:
//   IDLE | waiting for Start; operands are loaded on acceptance
//   RUN  | one bit added per edge, LSB first
//   DONE | result valid, Done pulse, back to IDLE unconditionally

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             Cin,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, sh_s, sh_s_nxt;
  logic             c_reg, c_nxt;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             cin_init;
  logic             p, g0, s_bit, g1;

`ifdef SERIAL_ADDER_CIN_EN
  assign cin_init = Cin;
`else
  assign cin_init = 1'b0;
`endif

  // Full-adder slice: two half adders plus an OR.
  half_adder u_ha0 (.a(sh_a[0]), .b(sh_b[0]), .s(p),     .c(g0));
  half_adder u_ha1 (.a(p),       .b(c_reg),   .s(s_bit), .c(g1));
  assign c_nxt = g0 | g1;

  // The new bit enters at the MSB. After WIDTH shifts, bit 0 has reached
  // position 0.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sh_s_nxt = s_bit;
    end else begin : g_wn
      assign sh_s_nxt = {s_bit, sh_s[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: if (Start) state_nxt = RUN;
      RUN: begin
        Busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      sh_s  <= '0;
      c_reg <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Carry <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          sh_a  <= A;
          sh_b  <= B;
          c_reg <= cin_init;
          cnt   <= '0;
        end
        RUN: begin
          sh_s  <= sh_s_nxt;
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          c_reg <= c_nxt;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            Sum   <= sh_s_nxt;
            Carry <= c_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
